phase_cmd_ctrl: RTL
===================

// Module: phase_cmd_ctrl
// PURPOSE
//  Command controller between the proto245a RX/TX FIFOs and the per-channel PWM phase registers.
//  Pops host bytes from the RX FIFO and parses fixed-length packets.
//  Stages phase writes in shadow registers and commits all channels atomically on the next period tick.
//  Returns ACK/NAK bytes through the TX FIFO.
// PARAMETERS
//  NUM_CHANNELS   2       number of transducer channels
//  PHASE_W        8       phase width; = $clog2(CLK_FREQ/OUT_FREQ)
//  PERIOD         256     counts per output period; legal phase is 0..PERIOD-1
//  TIMEOUT_CYC    65535   idle cycles allowed inside a partial packet before abort
// PORTS
//  clk            in   1        system clock (10.24 MHz PLL output)
//  rst            in   1        asynchronous active-high reset
//  period_tick    in   1        1-cycle pulse at start of each 40 kHz output period
//  rxfifo_data    in   8        RX FIFO read data
//  rxfifo_valid   in   1        rxfifo_data valid; 1 cycle after rxfifo_rd
//  rxfifo_empty   in   1        RX FIFO empty
//  rxfifo_rd      out  1        RX FIFO pop strobe
//  txfifo_full    in   1        TX FIFO full
//  txfifo_wr      out  1        TX FIFO push strobe
//  txfifo_data    out  8        TX FIFO write data
//  phases         out  [NUM_CHANNELS][PHASE_W]  active phase per channel
//  commit_pending out  1        commit requested, not yet applied
//  read_error     out  1        sticky protocol error; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; phases and shadow registers 0; FSM in S_OP.
//  Packets (first byte is opcode):
//   0x01 SET  ch ph -> shadow[ch] <= ph; no reply.
//   0x02 COMMIT     -> set commit_pending; reply 0xA5.
//   Any other opcode -> NAK 0x5A, read_error <= 1, return to S_OP.
//  Byte fetch:
//   rxfifo_rd asserts for exactly 1 cycle, only when !rxfifo_empty and no read is outstanding.
//   The FSM waits for rxfifo_valid before it consumes the byte.
//   At most one read is outstanding at any time.
//  FSM states:
//   S_OP -> S_CH (SET) | S_ACK (COMMIT) | S_NAK (bad opcode)
//   S_CH -> S_PH
//   S_PH -> S_OP
//   S_ACK/S_NAK -> S_OP once the reply is pushed
//  Range checks:
//   ch >= NUM_CHANNELS or ph >= PERIOD: packet is fully consumed; shadow is unchanged.
//   The controller then sends NAK and sets read_error.
//  Reply push:
//   txfifo_wr is a 1-cycle strobe, issued only when !txfifo_full.
//   When txfifo_full, the FSM holds in S_ACK/S_NAK; the reply is never dropped.
//   Reading from the RX FIFO stalls meanwhile.
//  Commit:
//   On period_tick with commit_pending=1: phases <= shadow (all channels in the same cycle).
//   commit_pending clears in that same cycle.
//   COMMIT accepted in the same cycle as period_tick: apply on the NEXT tick (no same-cycle bypass).
//   A second COMMIT while pending still sends ACK; it merges into the one pending commit.
//  Timeout:
//   In S_CH/S_PH, a cycle counter starts at the first cycle with no byte consumed.
//   At TIMEOUT_CYC it aborts to S_OP, discards the partial packet and sets read_error; no reply.
//   The counter resets on every consumed byte and in S_OP.
//  Async reset mid-packet or mid-pending: everything returns to reset values, including discarding the pending commit.
//   Bytes already popped are lost; the host must resync.
// CONFIGURATION
//  PHASE_READBACK_EN defined:
//   Opcode 0x03 GET ch -> reply 1 byte = phases[ch] (the active value, zero-extended to 8).
//   Invalid ch -> NAK, read_error.
//  PHASE_READBACK_EN undefined: 0x03 is treated as an unknown opcode (NAK, read_error).
// STRUCTURE
//  Package phase_ctrl_pkg holds:
//   typedef enum for opcodes (OP_SET=8'h01, OP_COMMIT=8'h02, OP_GET=8'h03)
//   constants ACK=8'hA5 and NAK=8'h5A
//   FSM state typedef
//  One sub-module, rx_byte_fetch:
//   Owns rxfifo_rd and the outstanding-read flag.
//   Presents a byte/valid/ready handshake to the FSM.
// TESTING
//  1. SET ch0=0x40, SET ch1=0x80, COMMIT; tick 20 cycles later
//     -> TX 0xA5; phases stay {0,0} until the tick, then {0x40,0x80} on the cycle after it.
//  2. Opcode 0x7F -> TX 0x5A, read_error=1; a following valid SET/COMMIT still works.
//  3. SET ch=2 ph=0x10 -> NAK; shadow/phases unchanged.
//     SET ch0 ph=0xFF with PERIOD=200 -> NAK.
//  4. txfifo_full held 50 cycles during COMMIT -> no txfifo_wr, no rxfifo_rd;
//     single 0xA5 pushed on the first non-full cycle.
//  5. Send 0x01,0x00 then starve RX for TIMEOUT_CYC
//     -> read_error=1, FSM in S_OP; next packet parses correctly.
//  6. PHASE_READBACK_EN: SET ch1=0x33, COMMIT, tick, GET 1 -> TX 0xA5 then 0x33.
//     Assert rst mid-packet -> phases=0, commit_pending=0.

Source files
------------

// File: rtl/phase_ctrl_pkg.sv
// Shared opcodes, reply bytes and FSM states for phase_cmd_ctrl.
// Optional feature macro: PHASE_READBACK_EN (enables the GET opcode).
package phase_ctrl_pkg;

  typedef enum logic [7:0] {
    OP_SET    = 8'h01,
    OP_COMMIT = 8'h02,
    OP_GET    = 8'h03
  } opcode_e;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'h5A;

  typedef enum logic [2:0] {
    S_OP,
    S_CH,
    S_PH,
    S_ACK,
    S_NAK,
    S_GCH,
    S_DAT
  } state_e;

endpackage

// File: rtl/rx_byte_fetch.sv
// Single-outstanding RX FIFO reader; buffers one byte behind a valid/take handshake.
// Optional feature macro: PHASE_READBACK_EN (no effect in this block).
module rx_byte_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_take,
  input  logic       i_rx_empty,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_rx_rd,
  output logic [7:0] o_byte,
  output logic       o_valid
);

  logic       r_pend;
  logic       r_have;
  logic [7:0] r_byte;

  // A pop is issued only with an empty buffer, so nothing is ever fetched
  // ahead while the consumer is busy pushing a reply.
  assign o_rx_rd = i_en && !i_rx_empty && !r_pend && !r_have;
  assign o_byte  = r_byte;
  assign o_valid = r_have;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_have <= 1'b0;
      r_byte <= '0;
    end else begin
      if (o_rx_rd)
        r_pend <= 1'b1;
      else if (i_rx_valid)
        r_pend <= 1'b0;

      if (i_rx_valid && r_pend) begin
        r_have <= 1'b1;
        r_byte <= i_rx_data;
      end else if (i_take) begin
        r_have <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/phase_cmd_ctrl.sv
// Host packet parser with shadowed phase registers committed atomically on period_tick.
// Optional feature macro: PHASE_READBACK_EN (adds opcode 0x03 GET ch -> active phase byte).
module phase_cmd_ctrl
  import phase_ctrl_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int PHASE_W      = 8,
  parameter int PERIOD       = 256,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 period_tick,
  input  logic [7:0]                           rxfifo_data,
  input  logic                                 rxfifo_valid,
  input  logic                                 rxfifo_empty,
  output logic                                 rxfifo_rd,
  input  logic                                 txfifo_full,
  output logic                                 txfifo_wr,
  output logic [7:0]                           txfifo_data,
  output logic [NUM_CHANNELS-1:0][PHASE_W-1:0] phases,
  output logic                                 commit_pending,
  output logic                                 read_error
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_e                             r_state, w_next;
  logic [7:0]                         r_ch;
  logic [NUM_CHANNELS-1:0][PHASE_W-1:0] r_shadow;
  logic [NUM_CHANNELS-1:0][PHASE_W-1:0] r_phases;
  logic                               r_pend;
  logic                               r_err;
  logic [CW-1:0]                      r_cnt;

  logic       w_en, w_take, w_wait, w_timeout;
  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_load_ch, w_set_shadow, w_commit_req, w_set_err;
  logic       w_ch_ok, w_ph_ok;

  rx_byte_fetch u_fetch (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_en),
    .i_take     (w_take),
    .i_rx_empty (rxfifo_empty),
    .i_rx_valid (rxfifo_valid),
    .i_rx_data  (rxfifo_data),
    .o_rx_rd    (rxfifo_rd),
    .o_byte     (w_byte),
    .o_valid    (w_byte_valid)
  );

  assign w_en      = (r_state == S_OP) || (r_state == S_CH) ||
                     (r_state == S_PH) || (r_state == S_GCH);
  assign w_take    = w_en && w_byte_valid;
  assign w_wait    = (r_state == S_CH) || (r_state == S_PH) || (r_state == S_GCH);
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign w_ch_ok   = ({24'd0, r_ch} < 32'(NUM_CHANNELS));
  assign w_ph_ok   = ({24'd0, w_byte} < 32'(PERIOD));

  assign phases         = r_phases;
  assign commit_pending = r_pend;
  assign read_error     = r_err;

`ifdef PHASE_READBACK_EN
  logic [7:0] r_dat;
  logic [7:0] w_dat_sel;
  logic       w_get_ok;
  logic       w_load_dat;

  assign w_get_ok = ({24'd0, w_byte} < 32'(NUM_CHANNELS));

  always_comb begin
    w_dat_sel = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++)
      if (w_byte == 8'(i)) w_dat_sel = 8'(r_phases[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_dat <= '0;
    else if (w_load_dat) r_dat <= w_dat_sel;
  end
`endif

  always_comb begin
    w_next       = r_state;
    w_load_ch    = 1'b0;
    w_set_shadow = 1'b0;
    w_commit_req = 1'b0;
    w_set_err    = 1'b0;
    txfifo_wr    = 1'b0;
    txfifo_data  = '0;
`ifdef PHASE_READBACK_EN
    w_load_dat   = 1'b0;
`endif
    case (r_state)
      S_OP: begin
        if (w_take) begin
          case (w_byte)
            OP_SET:    w_next = S_CH;
            OP_COMMIT: begin
              w_commit_req = 1'b1;
              w_next       = S_ACK;
            end
`ifdef PHASE_READBACK_EN
            OP_GET:    w_next = S_GCH;
`endif
            default: begin
              w_set_err = 1'b1;
              w_next    = S_NAK;
            end
          endcase
        end
      end
      S_CH: begin
        if (w_take) begin
          w_load_ch = 1'b1;
          w_next    = S_PH;
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = S_OP;
        end
      end
      S_PH: begin
        if (w_take) begin
          if (w_ch_ok && w_ph_ok) begin
            w_set_shadow = 1'b1;
            w_next       = S_OP;
          end else begin
            w_set_err = 1'b1;
            w_next    = S_NAK;
          end
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = S_OP;
        end
      end
`ifdef PHASE_READBACK_EN
      // GET's channel byte is guarded by the same idle timeout as SET.
      S_GCH: begin
        if (w_take) begin
          if (w_get_ok) begin
            w_load_dat = 1'b1;
            w_next     = S_DAT;
          end else begin
            w_set_err = 1'b1;
            w_next    = S_NAK;
          end
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = S_OP;
        end
      end
      S_DAT: begin
        txfifo_data = r_dat;
        if (!txfifo_full) begin
          txfifo_wr = 1'b1;
          w_next    = S_OP;
        end
      end
`endif
      S_ACK: begin
        txfifo_data = ACK;
        if (!txfifo_full) begin
          txfifo_wr = 1'b1;
          w_next    = S_OP;
        end
      end
      S_NAK: begin
        txfifo_data = NAK;
        if (!txfifo_full) begin
          txfifo_wr = 1'b1;
          w_next    = S_OP;
        end
      end
      default: w_next = S_OP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_OP;
      r_ch     <= '0;
      r_shadow <= '0;
      r_phases <= '0;
      r_pend   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_ch) r_ch <= w_byte;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++)
        if (w_set_shadow && (r_ch == 8'(i))) r_shadow[i] <= PHASE_W'(w_byte);
      if (period_tick && r_pend) r_phases <= r_shadow;
      // A COMMIT landing on the tick cycle stays pending for the next tick.
      if (w_commit_req)     r_pend <= 1'b1;
      else if (period_tick) r_pend <= 1'b0;
      if (w_set_err) r_err <= 1'b1;
      if (w_wait && !w_take) r_cnt <= r_cnt + CW'(1);
      else                   r_cnt <= '0;
    end
  end

endmodule
